// File: rtl/mem_access_unit.sv
// Data-memory responder for the multicycle RV32 core: one load/store at a time,
// checked for legality, delayed by WAIT_CYCLES, then a lane-accurate RAM access.
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state;
    logic [3:0]        wait_cnt;

    logic              l_write;
    logic [2:0]        l_f3;
    logic [ADDR_W-1:0] l_idx;
    logic [1:0]        l_lane;
    logic [31:0]       l_wdata;

    logic [31:0]       mem [0:(2**ADDR_W)-1];

    logic              f3_legal;
    logic              misalign;
    logic              out_of_range;
    logic              req_err;

    logic [3:0]        be;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    // Legality of the live request, evaluated only when IDLE accepts it.
    always_comb begin
        f3_legal = 1'b0;
        if (req_write) begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end

        case (funct3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase

        out_of_range = |addr[31:ADDR_W+2];
        req_err      = !f3_legal || misalign || out_of_range;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (l_f3[1:0])
            2'b00: begin
                be      = 4'b0001 << l_lane;
                wr_word = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be      = l_lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{l_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_word = l_wdata;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem[l_idx];
        rd_shift = rd_word >> {l_lane, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = l_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (l_f3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // RAM is not reset; a reset forces IDLE, so an aborted store never reaches ACCESS.
    always_ff @(posedge CLK) begin
        if (state == S_ACCESS && l_write) begin
            if (be[0]) mem[l_idx][7:0]   <= wr_word[7:0];
            if (be[1]) mem[l_idx][15:8]  <= wr_word[15:8];
            if (be[2]) mem[l_idx][23:16] <= wr_word[23:16];
            if (be[3]) mem[l_idx][31:24] <= wr_word[31:24];
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            l_write  <= 1'b0;
            l_f3     <= '0;
            l_idx    <= '0;
            l_lane   <= '0;
            l_wdata  <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_write <= req_write;
                        l_f3    <= funct3;
                        l_idx   <= addr[ADDR_W+1:2];
                        l_lane  <= addr[1:0];
                        l_wdata <= wdata;
                        if (req_err) begin
                            err   <= 1'b1;
                            rdata <= '0;
                            state <= S_RESP;
                        end else begin
                            err      <= 1'b0;
                            wait_cnt <= WAIT_INIT;
                            state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    rdata <= l_write ? '0 : load_val;
                    state <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_RESP);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the multicycle RV32 core: the other end of the load/store request that the control sequencer issues in its memory-access state.
- Accepts one load or store request, checks alignment, range and size encoding, and waits a programmable number of cycles.
- Performs a byte-lane-accurate access to an internal word-organised RAM.
- Returns a single-cycle done pulse with sign- or zero-extended read data or an error flag.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted before the RAM access (0..15).

Ports:
- CLK  input  1  system clock, rising edge
- RES  input  1  asynchronous, active-high reset
- req_valid  input  1  request strobe, sampled only in IDLE
- req_write  input  1  1 = store, 0 = load
- funct3  input  3  RV32 size/sign field
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; request rejected
- rdata  output  32  load result, valid with done, held until the next accept

Behaviour:
- Reset: state=IDLE; busy=0, done=0, err=0, rdata=0. RAM contents are not cleared.
- Reset mid-operation aborts the request. No RAM write occurs unless the ACCESS edge has already passed.
- Legal funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3, stores: 000 SB, 001 SH, 010 SW.
- Error conditions (checked at the accepting edge):
  - illegal funct3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_W+2] != 0.
- Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0].
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on req_valid, latch all request fields.
    - Error: go to RESP with err=1 and rdata=0.
    - Else if WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
    - Else: go to ACCESS.
  - WAIT: decrement the counter; go to ACCESS when the counter is 0.
  - ACCESS: one cycle. At its closing edge:
    - stores write only the selected lanes (SB: lane addr[1:0] <= wdata[7:0]; SH: lanes addr[1]*2+1:addr[1]*2 <= wdata[15:0]; SW: all four lanes);
    - loads register the extracted value (LB/LH sign-extended, LBU/LHU zero-extended, LW whole word) into rdata;
    - stores set rdata=0;
    - go to RESP.
  - RESP: done=1 for exactly one cycle, err as latched; go to IDLE unconditionally.
- Latency from the accepting edge to the start of the done cycle: WAIT_CYCLES+2 edges for a legal request, 1 edge for an error.
- busy is high in WAIT, ACCESS and RESP.
- req_valid outside IDLE is ignored (not queued). A request held high through RESP is re-accepted in the following IDLE cycle.
- Back-to-back throughput: one request per WAIT_CYCLES+3 cycles.
- Request inputs may change after the accepting edge; only latched copies are used.
- Read-after-write to the same word in consecutive requests returns the newly written data.
- rdata and err are held after done until the next accept.

Test Plan:
- Reset: assert RES mid-WAIT of SW 0x00000010 <= 0xDEADBEEF -> busy=0, done=0, rdata=0 immediately; a later LW 0x10 does not return 0xDEADBEEF.
- SW 0x20 <= 0x11223344, then LW 0x20 with WAIT_CYCLES=2 -> done exactly 4 edges after the accept, err=0, rdata=0x11223344; busy high in all 3 prior cycles.
- Lanes: SB 0x23 <= 0x000000AA, then SH 0x20 <= 0x0000BEEF.
  - LW 0x20 -> 0xAA22BEEF.
  - LB 0x23 -> 0xFFFFFFAA; LBU 0x23 -> 0x000000AA.
  - LH 0x20 -> 0xFFFFBEEF; LHU 0x22 -> 0x0000AA22.
- Errors:
  - LW 0x22 -> done 1 edge after the accept, err=1, rdata=0, RAM word 0x20 unchanged.
  - SH 0x21 -> err=1.
  - funct3=011 -> err=1.
  - addr 0x00001000 (ADDR_W=10) -> err=1.
- Handshake: pulse req_valid during WAIT with a different address -> ignored; one done pulse only, data from the first request.
- WAIT_CYCLES=0 build: LW accepted -> done 2 edges later; continuous req_valid -> one done every 3 cycles.
